// File: rtl/memory_mapper_if.sv
// Z80-side bus and memory-controller handshake between the CPU glue and the paging unit.
// The mapper uses the slave view; whatever drives the CPU bus and the memory
// controller uses the master view.
interface memory_mapper_if #(
    parameter int AW = 22
);
    logic          ce;
    logic          iorq;
    logic          mreq;
    logic          rd;
    logic          wr;
    logic [15:0]   a;
    logic [7:0]    d;
    logic [7:0]    q;
    logic          waitn;
    logic [AW-1:0] memA;
    logic [7:0]    memD;
    logic [7:0]    memQ;
    logic          memR;
    logic          memW;
    logic          memAck;

    modport slave (
        input  ce, iorq, mreq, rd, wr, a, d, memQ, memAck,
        output q, waitn, memA, memD, memR, memW
    );

    modport master (
        output ce, iorq, mreq, rd, wr, a, d, memQ, memAck,
        input  q, waitn, memA, memD, memR, memW
    );
endinterface

// File: rtl/memory_mapper.sv
// Paging unit plus external-memory sequencer. The 64K CPU space is split into
// SLOTS slots, each mapped through an I/O-written page register. Every CPU memory
// cycle becomes one req/ack transaction, with waitn holding the CPU meanwhile.
// Writes to low ROM pages are swallowed; a lost ack is recovered by a timeout.
module memory_mapper #(
    parameter int         SLOTS     = 4,
    parameter int         PAGE_W    = 8,
    parameter logic [7:0] IO_BASE   = 8'hB0,
    parameter int         ROM_PAGES = 4,
    parameter int         TIMEOUT   = 64
) (
    input  logic           clock,
    input  logic           reset,
    memory_mapper_if.slave bus
);
    localparam int SB = $clog2(SLOTS);
    localparam int OW = 16 - SB;
    localparam int AW = PAGE_W + OW;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [PAGE_W-1:0] page_q [SLOTS];
    logic [AW-1:0]     memA_q, memA_d;
    logic [7:0]        memD_q, memD_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              memR_q, memR_d;
    logic              memW_q, memW_d;
    logic              waitn_q, waitn_d;
    logic              dir_q, dir_d;      // 1 = write transaction
    logic [CW-1:0]     cnt_q, cnt_d;

    // I/O decode: offset from IO_BASE wraps mod 256, so only the SLOTS ports above it hit.
    logic [7:0]        io_off;
    logic              io_hit;
    logic [SB-1:0]     io_idx;
    logic [SB-1:0]     slot;
    logic [PAGE_W-1:0] cur_page;
    logic              start;

    assign io_off   = bus.a[7:0] - IO_BASE;
    assign io_hit   = int'(io_off) < SLOTS;
    assign io_idx   = io_off[SB-1:0];
    assign slot     = bus.a[15:OW];
    assign cur_page = page_q[slot];
    // Refresh cycles (mreq low with rd and wr high) never start a transaction.
    assign start    = bus.ce && !bus.mreq && (!bus.rd || !bus.wr);

    function automatic logic is_rom(input logic [PAGE_W-1:0] page);
        return int'(page) < ROM_PAGES;
    endfunction

    // Page registers are written from OUT instructions to the slot ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) page_q[i] <= '0;
        end else if (bus.ce && !bus.iorq && !bus.wr && io_hit) begin
            page_q[io_idx] <= bus.d[PAGE_W-1:0];
        end
    end

    // Sequencer next-state and registered outputs.
    always_comb begin
        state_d = state_q;
        memA_d  = memA_q;
        memD_d  = memD_q;
        rdata_d = rdata_q;
        memR_d  = memR_q;
        memW_d  = memW_q;
        waitn_d = waitn_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    memA_d = {cur_page, bus.a[OW-1:0]};
                    memD_d = bus.d;
                    dir_d  = !bus.wr;
                    if (!bus.wr && is_rom(cur_page)) begin
                        state_d = DONE;
                    end else begin
                        memR_d  = bus.wr;
                        memW_d  = !bus.wr;
                        waitn_d = 1'b0;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (bus.memAck) begin
                    memR_d  = 1'b0;
                    memW_d  = 1'b0;
                    if (!dir_q) rdata_d = bus.memQ;
                    waitn_d = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    memR_d  = 1'b0;
                    memW_d  = 1'b0;
                    if (!dir_q) rdata_d = 8'hFF;
                    waitn_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Hold here until the CPU releases MREQ so each cycle runs once.
                if (bus.ce && bus.mreq) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            memA_q  <= '0;
            memD_q  <= '0;
            rdata_q <= 8'hFF;
            memR_q  <= 1'b0;
            memW_q  <= 1'b0;
            waitn_q <= 1'b1;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            memA_q  <= memA_d;
            memD_q  <= memD_d;
            rdata_q <= rdata_d;
            memR_q  <= memR_d;
            memW_q  <= memW_d;
            waitn_q <= waitn_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.q     = (!bus.iorq && io_hit) ? 8'(page_q[io_idx]) : rdata_q;
    assign bus.waitn = waitn_q;
    assign bus.memA  = memA_q;
    assign bus.memD  = memD_q;
    assign bus.memR  = memR_q;
    assign bus.memW  = memW_q;
endmodule

// File: tb/tb_memory_mapper.sv
// Directed bench for memory_mapper: a default 4-slot instance and an 8-slot,
// 6-bit-page instance share clock and reset.
module tb_memory_mapper;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    memory_mapper_if #(.AW(22)) bus ();
    memory_mapper_if #(.AW(19)) bus8 ();

    memory_mapper u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    memory_mapper #(.SLOTS(8), .PAGE_W(6)) u_dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8.slave)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic bus_idle();
        bus.ce = 1'b1;  bus.iorq = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1;
        bus.a = 16'h0;  bus.d = 8'h0;    bus.memQ = 8'h0; bus.memAck = 1'b0;
        bus8.ce = 1'b1; bus8.iorq = 1'b1; bus8.mreq = 1'b1; bus8.rd = 1'b1; bus8.wr = 1'b1;
        bus8.a = 16'h0; bus8.d = 8'h0;    bus8.memQ = 8'h0; bus8.memAck = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] port, input logic [7:0] data);
        bus.a = {8'h00, port}; bus.d = data; bus.iorq = 1'b0; bus.wr = 1'b0;
        tick();
        bus.iorq = 1'b1; bus.wr = 1'b1;
    endtask

    task automatic start_read(input logic [15:0] addr);
        bus.a = addr; bus.mreq = 1'b0; bus.rd = 1'b0;
        tick();
    endtask

    task automatic end_cycle();
        bus.mreq = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus_idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (bus.waitn !== 1'b1) begin errors++; $display("FAIL reset_waitn: got %b want 1", bus.waitn); end
        checks++; if (bus.memR !== 1'b0) begin errors++; $display("FAIL reset_memR: got %b want 0", bus.memR); end
        checks++; if (bus.memW !== 1'b0) begin errors++; $display("FAIL reset_memW: got %b want 0", bus.memW); end
        checks++; if (bus.memA !== 22'h0) begin errors++; $display("FAIL reset_memA: got %h want 0", bus.memA); end
        checks++; if (bus.memD !== 8'h0) begin errors++; $display("FAIL reset_memD: got %h want 0", bus.memD); end
        checks++; if (bus.q !== 8'hFF) begin errors++; $display("FAIL reset_q: got %h want ff", bus.q); end
        bus.a = 16'h00B2; bus.iorq = 1'b0; bus.rd = 1'b0; #1;
        checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_page2: got %h want 00", bus.q); end
        bus.iorq = 1'b1; bus.rd = 1'b1;
        tick();
    endtask

    task automatic test_read_paged();
        logic [21:0] exp_a;
        int rhigh, wlow, wbad, extra;
        exp_a = {8'h35, 14'h0123};
        io_write(8'hB2, 8'h35);
        bus.a = 16'h00B2; bus.iorq = 1'b0; bus.rd = 1'b0; #1;
        checks++; if (bus.q !== 8'h35) begin errors++; $display("FAIL in_page2: got %h want 35", bus.q); end
        bus.iorq = 1'b1; bus.rd = 1'b1;
        tick();
        bus.memQ = 8'h5A;
        start_read(16'h8123);
        checks++; if (bus.memA !== exp_a) begin errors++; $display("FAIL read_memA: got %h want %h", bus.memA, exp_a); end
        rhigh = 0; wlow = 0; wbad = 0;
        for (int k = 1; k <= 5; k++) begin
            if (bus.memR === 1'b1) rhigh++;
            if (bus.waitn === 1'b0) wlow++;
            if (bus.memW !== 1'b0) wbad++;
            if (k == 5) bus.memAck = 1'b1;
            tick();
        end
        bus.memAck = 1'b0;
        checks++; if (rhigh != 5) begin errors++; $display("FAIL read_memR_cycles: got %0d want 5", rhigh); end
        checks++; if (wlow != 5) begin errors++; $display("FAIL read_waitn_cycles: got %0d want 5", wlow); end
        checks++; if (wbad != 0) begin errors++; $display("FAIL read_memW_seen: got %0d want 0", wbad); end
        checks++; if (bus.memR !== 1'b0) begin errors++; $display("FAIL read_memR_drop: got %b want 0", bus.memR); end
        checks++; if (bus.waitn !== 1'b1) begin errors++; $display("FAIL read_waitn_rel: got %b want 1", bus.waitn); end
        checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL read_q: got %h want 5a", bus.q); end
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.memR !== 1'b0 || bus.waitn !== 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL read_single_pulse: got %0d extra want 0", extra); end
        end_cycle();
    endtask

    task automatic test_write();
        logic [21:0] exp_a;
        exp_a = {8'h10, 14'h0042};
        io_write(8'hB0, 8'h10);
        io_write(8'hB4, 8'h77);
        bus.a = 16'h00B0; bus.iorq = 1'b0; bus.rd = 1'b0; #1;
        checks++; if (bus.q !== 8'h10) begin errors++; $display("FAIL ignored_port: got %h want 10", bus.q); end
        bus.iorq = 1'b1; bus.rd = 1'b1;
        tick();
        bus.a = 16'h0042; bus.d = 8'h77; bus.mreq = 1'b0; bus.wr = 1'b0;
        tick();
        checks++; if (bus.memW !== 1'b1) begin errors++; $display("FAIL write_memW: got %b want 1", bus.memW); end
        checks++; if (bus.memR !== 1'b0) begin errors++; $display("FAIL write_memR: got %b want 0", bus.memR); end
        checks++; if (bus.memD !== 8'h77) begin errors++; $display("FAIL write_memD: got %h want 77", bus.memD); end
        checks++; if (bus.memA !== exp_a) begin errors++; $display("FAIL write_memA: got %h want %h", bus.memA, exp_a); end
        checks++; if (bus.waitn !== 1'b0) begin errors++; $display("FAIL write_waitn: got %b want 0", bus.waitn); end
        bus.memAck = 1'b1;
        tick();
        bus.memAck = 1'b0;
        checks++; if (bus.memW !== 1'b0 || bus.waitn !== 1'b1) begin errors++; $display("FAIL write_done: got memW=%b waitn=%b want 0 1", bus.memW, bus.waitn); end
        checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL write_keeps_rdata: got %h want 5a", bus.q); end
        end_cycle();
    endtask

    task automatic test_rom_protect();
        logic [21:0] exp_a;
        int bad;
        exp_a = {8'h02, 14'h0000};
        io_write(8'hB1, 8'h02);
        tick();
        bus.a = 16'h4000; bus.d = 8'hAA; bus.mreq = 1'b0; bus.wr = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.memW !== 1'b0 || bus.memR !== 1'b0 || bus.waitn !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rom_no_strobe: got %0d bad cycles want 0", bad); end
        checks++; if (bus.memA !== exp_a || bus.memD !== 8'hAA) begin errors++; $display("FAIL rom_latch: got %h/%h want %h/aa", bus.memA, bus.memD, exp_a); end
        end_cycle();
        io_write(8'hB1, 8'h04);
        tick();
        bus.a = 16'h4000; bus.d = 8'h55; bus.mreq = 1'b0; bus.wr = 1'b0;
        tick();
        checks++; if (bus.memW !== 1'b1) begin errors++; $display("FAIL rom_edge_page4: got memW=%b want 1", bus.memW); end
        bus.memAck = 1'b1;
        tick();
        bus.memAck = 1'b0;
        end_cycle();
    endtask

    task automatic test_timeout();
        int cnt;
        bus.memQ = 8'h99;
        start_read(16'h8000);
        cnt = 0;
        while (bus.memR === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        checks++; if (cnt != 64) begin errors++; $display("FAIL timeout_len: got %0d want 64", cnt); end
        checks++; if (bus.waitn !== 1'b1) begin errors++; $display("FAIL timeout_waitn: got %b want 1", bus.waitn); end
        checks++; if (bus.q !== 8'hFF) begin errors++; $display("FAIL timeout_q: got %h want ff", bus.q); end
        end_cycle();
        bus.memQ = 8'h3C;
        start_read(16'h8000);
        checks++; if (bus.memR !== 1'b1) begin errors++; $display("FAIL after_timeout_memR: got %b want 1", bus.memR); end
        bus.memAck = 1'b1;
        tick();
        bus.memAck = 1'b0;
        checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL after_timeout_q: got %h want 3c", bus.q); end
        end_cycle();
    endtask

    task automatic test_ack_at_timeout();
        int rhigh;
        bus.memQ = 8'hC3;
        start_read(16'h8000);
        rhigh = 0;
        for (int k = 1; k <= 64; k++) begin
            if (bus.memR === 1'b1) rhigh++;
            if (k == 64) bus.memAck = 1'b1;
            tick();
        end
        bus.memAck = 1'b0;
        checks++; if (rhigh != 64) begin errors++; $display("FAIL ack_last_cycles: got %0d want 64", rhigh); end
        checks++; if (bus.q !== 8'hC3) begin errors++; $display("FAIL ack_beats_timeout: got %h want c3", bus.q); end
        end_cycle();
    endtask

    task automatic test_refresh_and_ce();
        int bad;
        bus.a = 16'h0001; bus.mreq = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.memR !== 1'b0 || bus.waitn !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL refresh_no_cycle: got %0d bad want 0", bad); end
        bus.mreq = 1'b1;
        tick();
        bus.ce = 1'b0; bus.mreq = 1'b0; bus.rd = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.memR !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ce_gating: got %0d bad want 0", bad); end
        bus.ce = 1'b1;
        tick();
        checks++; if (bus.memR !== 1'b1) begin errors++; $display("FAIL ce_start: got %b want 1", bus.memR); end
        bus.memAck = 1'b1;
        tick();
        bus.memAck = 1'b0;
        end_cycle();
    endtask

    task automatic test_wide_slots();
        logic [18:0] exp_a;
        exp_a = {6'h3F, 13'h0000};
        bus8.a = 16'h00B7; bus8.d = 8'h3F; bus8.iorq = 1'b0; bus8.wr = 1'b0;
        tick();
        bus8.iorq = 1'b1; bus8.wr = 1'b1;
        bus8.a = 16'hE000; bus8.mreq = 1'b0; bus8.rd = 1'b0;
        tick();
        checks++; if (bus8.memA !== exp_a) begin errors++; $display("FAIL wide_memA: got %h want %h", bus8.memA, exp_a); end
        checks++; if (bus8.memR !== 1'b1) begin errors++; $display("FAIL wide_memR: got %b want 1", bus8.memR); end
        bus8.memQ = 8'h11; bus8.memAck = 1'b1;
        tick();
        bus8.memAck = 1'b0; bus8.mreq = 1'b1; bus8.rd = 1'b1;
        tick();
        bus8.a = 16'h00B7; bus8.iorq = 1'b0; bus8.rd = 1'b0; #1;
        checks++; if (bus8.q !== 8'h3F) begin errors++; $display("FAIL wide_in_b7: got %h want 3f", bus8.q); end
        bus8.iorq = 1'b1; bus8.rd = 1'b1;
        tick();
    endtask

    task automatic test_reset_in_req();
        bus.memQ = 8'h42;
        start_read(16'h8123);
        tick(); tick();
        checks++; if (bus.memR !== 1'b1) begin errors++; $display("FAIL rst_req_pre: got %b want 1", bus.memR); end
        reset = 1'b1; bus.mreq = 1'b1; bus.rd = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.memR !== 1'b0 || bus.waitn !== 1'b1) begin errors++; $display("FAIL rst_req_idle: got memR=%b waitn=%b want 0 1", bus.memR, bus.waitn); end
        checks++; if (bus.q !== 8'hFF) begin errors++; $display("FAIL rst_req_q: got %h want ff", bus.q); end
        bus.memAck = 1'b1;
        tick();
        bus.memAck = 1'b0;
        tick();
        checks++; if (bus.memR !== 1'b0 || bus.waitn !== 1'b1 || bus.q !== 8'hFF) begin errors++; $display("FAIL late_ack: got memR=%b waitn=%b q=%h want 0 1 ff", bus.memR, bus.waitn, bus.q); end
        start_read(16'h0010);
        checks++; if (bus.memR !== 1'b1 || bus.memA !== 22'h000010) begin errors++; $display("FAIL post_rst_read: got memR=%b memA=%h want 1 000010", bus.memR, bus.memA); end
        bus.memAck = 1'b1;
        tick();
        bus.memAck = 1'b0;
        checks++; if (bus.q !== 8'h42) begin errors++; $display("FAIL post_rst_q: got %h want 42", bus.q); end
        end_cycle();
    endtask

    initial begin
        test_reset();
        test_read_paged();
        test_write();
        test_rom_protect();
        test_timeout();
        test_ack_at_timeout();
        test_refresh_and_ce();
        test_wide_slots();
        test_reset_in_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
